// File: rtl/alarm_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alarm_seq_ctrl_if
// Purpose  : Counter-chain bus between the alarm sequencer and its counters.
// Revision : 1.0  initial release
// ============================================================================
interface alarm_seq_ctrl_if;
  logic       sec_z;
  logic       min_z;
  logic [6:0] sec_ct;
  logic [6:0] min_ct;
  logic [6:0] hr_ct;
  logic [6:0] amin_ct;
  logic [6:0] ahr_ct;
  logic       sec_en;
  logic       min_en;
  logic       hr_en;
  logic       amin_en;
  logic       ahr_en;
  logic       sec_clr;

  modport master (
    input  sec_z, min_z, sec_ct, min_ct, hr_ct, amin_ct, ahr_ct,
    output sec_en, min_en, hr_en, amin_en, ahr_en, sec_clr
  );

  modport slave (
    output sec_z, min_z, sec_ct, min_ct, hr_ct, amin_ct, ahr_ct,
    input  sec_en, min_en, hr_en, amin_en, ahr_en, sec_clr
  );
endinterface
`default_nettype wire

// File: rtl/alarm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_seq_ctrl
// Purpose  : Mode FSM, counter enable sequencing and buzzer control for an
//            alarm clock. Optional snooze support via ALARM_SNOOZE_EN.
// Revision : 1.0  initial release
// ============================================================================
module alarm_seq_ctrl #(
  parameter int BUZZ_SECS  = 10,
  parameter int SNOOZE_MIN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             set_time_i,
  input  logic             set_alarm_i,
  input  logic             adv_min_i,
  input  logic             adv_hr_i,
  input  logic             alarm_on_i,
  input  logic             snooze_i,
  alarm_seq_ctrl_if.master cnt,
  output logic [1:0]       mode_o,
  output logic             buzz_o
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SET_TIME  = 2'd1,
    ST_SET_ALARM = 2'd2
  } state_e;

  localparam logic [6:0] BUZZ_LIM = 7'(BUZZ_SECS);

  state_e     state_q, state_d;
  logic       buzz_q, buzz_d;
  logic [6:0] buzz_tmr_q, buzz_tmr_d;
  logic       match_q;
  logic       adv_min_q, adv_hr_q;

  logic       w_match, w_buzz_set, w_timeout, w_hold_ok;
  logic       w_rise_min, w_rise_hr;
  logic [6:0] w_tmr_inc;

  assign w_match    = (cnt.min_ct == cnt.amin_ct) && (cnt.hr_ct == cnt.ahr_ct)
                   && (cnt.sec_ct == 7'd0);
  assign w_hold_ok  = alarm_on_i && (state_q == ST_RUN);
  assign w_buzz_set = w_match && !match_q && w_hold_ok;
  assign w_tmr_inc  = buzz_tmr_q + 7'd1;
  assign w_timeout  = buzz_q && tick_i && (w_tmr_inc == BUZZ_LIM);
  assign w_rise_min = adv_min_i && !adv_min_q;
  assign w_rise_hr  = adv_hr_i && !adv_hr_q;

`ifdef ALARM_SNOOZE_EN
  localparam logic [12:0] SNZ_LOAD = 13'(SNOOZE_MIN * 60);

  logic        snooze_q;
  logic        snz_pend_q, snz_pend_d;
  logic [12:0] snz_tmr_q, snz_tmr_d;
  logic        w_snz_rise;

  assign w_snz_rise = snooze_i && !snooze_q;
`else
  logic        unused_snooze_in;
  logic [12:0] unused_snooze_cfg;

  assign unused_snooze_in  = snooze_i;
  assign unused_snooze_cfg = 13'(SNOOZE_MIN);
`endif

  always_comb begin
    state_d    = ST_RUN;
    buzz_d     = buzz_q;
    buzz_tmr_d = buzz_tmr_q;
    if (set_time_i) begin
      state_d = ST_SET_TIME;
    end else if (set_alarm_i) begin
      state_d = ST_SET_ALARM;
    end

    if (buzz_q && tick_i) begin
      buzz_tmr_d = w_tmr_inc;
    end
    if (w_buzz_set) begin
      buzz_d     = 1'b1;
      buzz_tmr_d = 7'd0;
    end

`ifdef ALARM_SNOOZE_EN
    snz_pend_d = snz_pend_q;
    snz_tmr_d  = snz_tmr_q;
    if (snz_pend_q && tick_i) begin
      snz_tmr_d = snz_tmr_q - 13'd1;
      if (snz_tmr_q == 13'd1) begin
        snz_pend_d = 1'b0;
        buzz_d     = 1'b1;
        buzz_tmr_d = 7'd0;
      end
    end
    if (w_snz_rise && buzz_q) begin
      buzz_d     = 1'b0;
      buzz_tmr_d = 7'd0;
      snz_pend_d = 1'b1;
      snz_tmr_d  = SNZ_LOAD;
    end
    if (!w_hold_ok) begin
      snz_pend_d = 1'b0;
      snz_tmr_d  = 13'd0;
    end
`endif

    // Clearing conditions override any set decided above.
    if (!w_hold_ok || w_timeout) begin
      buzz_d     = 1'b0;
      buzz_tmr_d = 7'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      buzz_q     <= 1'b0;
      buzz_tmr_q <= 7'd0;
      match_q    <= 1'b0;
      adv_min_q  <= 1'b0;
      adv_hr_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_q   <= 1'b0;
      snz_pend_q <= 1'b0;
      snz_tmr_q  <= 13'd0;
`endif
    end else begin
      state_q    <= state_d;
      buzz_q     <= buzz_d;
      buzz_tmr_q <= buzz_tmr_d;
      match_q    <= w_match;
      adv_min_q  <= adv_min_i;
      adv_hr_q   <= adv_hr_i;
`ifdef ALARM_SNOOZE_EN
      snooze_q   <= snooze_i;
      snz_pend_q <= snz_pend_d;
      snz_tmr_q  <= snz_tmr_d;
`endif
    end
  end

  logic w_sec_en, w_min_en, w_hr_en, w_amin_en, w_ahr_en, w_sec_clr;

  always_comb begin
    w_sec_en  = 1'b0;
    w_min_en  = 1'b0;
    w_hr_en   = 1'b0;
    w_amin_en = 1'b0;
    w_ahr_en  = 1'b0;
    w_sec_clr = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          w_sec_en = tick_i;
          w_min_en = tick_i && cnt.sec_z;
          w_hr_en  = tick_i && cnt.sec_z && cnt.min_z;
        end
        ST_SET_TIME: begin
          w_sec_clr = 1'b1;
          w_min_en  = w_rise_min;
          w_hr_en   = w_rise_hr;
        end
        ST_SET_ALARM: begin
          w_sec_en  = tick_i;
          w_min_en  = tick_i && cnt.sec_z;
          w_hr_en   = tick_i && cnt.sec_z && cnt.min_z;
          w_amin_en = w_rise_min;
          w_ahr_en  = w_rise_hr;
        end
        default: begin
          w_sec_en = 1'b0;
        end
      endcase
    end
  end

  assign cnt.sec_en  = w_sec_en;
  assign cnt.min_en  = w_min_en;
  assign cnt.hr_en   = w_hr_en;
  assign cnt.amin_en = w_amin_en;
  assign cnt.ahr_en  = w_ahr_en;
  assign cnt.sec_clr = w_sec_clr;
  assign mode_o      = state_q;
  assign buzz_o      = buzz_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_seq_ctrl
// Purpose  : Scoreboard bench for alarm_seq_ctrl (directed vectors).
// Revision : 1.0  initial release
// ============================================================================
module tb_alarm_seq_ctrl;
  logic       clk = 1'b1;
  logic       rst, tick, set_time, set_alarm, adv_min, adv_hr, alarm_on, snooze;
  logic [1:0] mode;
  logic       buzz;

  alarm_seq_ctrl_if bus();

  alarm_seq_ctrl #(.BUZZ_SECS(10), .SNOOZE_MIN(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_i      (tick),
    .set_time_i  (set_time),
    .set_alarm_i (set_alarm),
    .adv_min_i   (adv_min),
    .adv_hr_i    (adv_hr),
    .alarm_on_i  (alarm_on),
    .snooze_i    (snooze),
    .cnt         (bus.master),
    .mode_o      (mode),
    .buzz_o      (buzz)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] SEC  = 9'h100;
  localparam logic [8:0] MIN  = 9'h080;
  localparam logic [8:0] HR   = 9'h040;
  localparam logic [8:0] AMIN = 9'h020;
  localparam logic [8:0] AHR  = 9'h010;
  localparam logic [8:0] CLR  = 9'h008;
  localparam logic [8:0] MODE = 9'h006;
  localparam logic [8:0] BUZ  = 9'h001;
  localparam logic [8:0] EN   = 9'h1F8;
  localparam logic [8:0] ALL  = 9'h1FF;

  typedef struct {
    logic [8:0] val;
    logic [8:0] msk;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  wire [8:0] act = {bus.sec_en, bus.min_en, bus.hr_en, bus.amin_en, bus.ahr_en,
                    bus.sec_clr, mode, buzz};

  function automatic logic [8:0] md(input logic [1:0] m);
    return {6'b0, m, 1'b0};
  endfunction

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.msk != 9'h0) begin
        checks++;
        if ((act & e.msk) !== (e.val & e.msk)) begin
          failures++;
          $display("FAIL %s: got %b required %b (mask %b) at %0t",
                   e.nm, act & e.msk, e.val & e.msk, e.msk, $time);
        end
      end
    end
  end

  task automatic cyc(input logic [8:0] v, input logic [8:0] m, input string nm);
    exp_t e;
    e.val = v;
    e.msk = m;
    e.nm  = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Time crosses 07:29:59 -> 07:30:00 with the alarm at 07:30.
  task automatic trigger(input logic exp_on);
    bus.hr_ct  = 7'd7;
    bus.min_ct = 7'd29;
    bus.sec_ct = 7'd59;
    bus.sec_z  = 1'b1;
    tick = 1'b1;
    cyc(SEC | MIN, EN | BUZ, "pre_match");
    tick = 1'b0;
    bus.sec_z  = 1'b0;
    bus.min_ct = 7'd30;
    bus.sec_ct = 7'd0;
    cyc(9'h0, EN | BUZ, "match_cycle");
    cyc(exp_on ? BUZ : 9'h0, EN | BUZ | MODE, "buzz_after_match");
  endtask

  task automatic tick_pair(input logic buzz_during, input logic buzz_after, input string nm);
    tick = 1'b1;
    cyc(SEC | (buzz_during ? BUZ : 9'h0), SEC | BUZ, nm);
    tick = 1'b0;
    bus.sec_ct = bus.sec_ct + 7'd1;
    cyc(buzz_after ? BUZ : 9'h0, BUZ, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b1; set_time = 1'b0; set_alarm = 1'b0;
    adv_min = 1'b0; adv_hr = 1'b0; alarm_on = 1'b0; snooze = 1'b0;
    bus.sec_z = 1'b1; bus.min_z = 1'b1;
    bus.sec_ct = 7'd0; bus.min_ct = 7'd0; bus.hr_ct = 7'd0;
    bus.amin_ct = 7'd30; bus.ahr_ct = 7'd7;
    #1;
    cyc(9'h0, EN, "rst_enables");
    cyc(9'h0, ALL, "rst_state");
    rst = 1'b0; tick = 1'b0; bus.sec_z = 1'b0; bus.min_z = 1'b0;

    // 60 ticks in RUN: exactly one min_en, on the sec_z tick.
    for (int i = 0; i < 60; i++) begin
      bus.sec_ct = 7'(i);
      bus.sec_z  = (i == 59);
      tick = 1'b1;
      cyc(SEC | ((i == 59) ? MIN : 9'h0), EN | MODE | BUZ, "run_tick");
      tick = 1'b0;
      bus.sec_z = 1'b0;
      cyc(9'h0, EN, "run_idle");
    end
    bus.sec_ct = 7'd0;
    bus.min_ct = 7'd1;

    bus.sec_z = 1'b1; bus.min_z = 1'b1; tick = 1'b1;
    cyc(SEC | MIN | HR, EN, "carry_all");
    tick = 1'b0; bus.sec_z = 1'b0; bus.min_z = 1'b0;

    // Time-set mode with a held minute button.
    set_time = 1'b1;
    cyc(md(2'd0), EN | MODE, "set_time_latency");
    cyc(CLR | md(2'd1), EN | MODE, "set_time_mode");
    adv_min = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick = ((i % 7) == 3);
      bus.sec_z = 1'b1; bus.min_z = 1'b1;
      cyc(CLR | md(2'd1) | ((i == 0) ? MIN : 9'h0), EN | MODE, "adv_min_hold");
    end
    tick = 1'b0; bus.sec_z = 1'b0; bus.min_z = 1'b0; adv_min = 1'b0;
    cyc(CLR | md(2'd1), EN | MODE, "adv_min_release");
    adv_hr = 1'b1;
    cyc(CLR | md(2'd1) | HR, EN, "adv_hr_rise");
    cyc(CLR | md(2'd1), EN, "adv_hr_hold");
    adv_hr = 1'b0;
    cyc(CLR, EN, "adv_hr_release");

    // Both requests: time-set wins; then alarm-set.
    set_alarm = 1'b1;
    cyc(CLR | md(2'd1), EN | MODE, "both_requests");
    set_time = 1'b0;
    cyc(CLR | md(2'd1), EN | MODE, "drop_set_time_latency");
    cyc(md(2'd2), EN | MODE, "set_alarm_mode");
    adv_hr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(md(2'd2) | ((i == 0) ? AHR : 9'h0), EN | MODE, "ahr_press");
    end
    adv_hr = 1'b0;
    adv_min = 1'b1;
    cyc(md(2'd2) | AMIN, EN | MODE, "amin_rise");
    adv_min = 1'b0;
    tick = 1'b1; bus.sec_z = 1'b1;
    cyc(md(2'd2) | SEC | MIN, EN | MODE, "set_alarm_chain_runs");
    tick = 1'b0; bus.sec_z = 1'b0;

    // Match while not in RUN must not buzz.
    alarm_on = 1'b1;
    bus.hr_ct = 7'd7; bus.min_ct = 7'd30; bus.sec_ct = 7'd0;
    cyc(md(2'd2), MODE | BUZ, "match_in_set_alarm");
    cyc(md(2'd2), MODE | BUZ, "no_buzz_set_alarm");
    set_alarm = 1'b0;
    cyc(md(2'd2), MODE | BUZ, "leave_set_alarm");
    cyc(md(2'd0), MODE | BUZ, "back_run_no_buzz");
    bus.sec_ct = 7'd1;
    cyc(9'h0, BUZ, "idle_no_buzz");

    // Alarm match: buzz for 10 ticks.
    trigger(1'b1);
    for (int k = 1; k <= 10; k++) tick_pair(1'b1, k < 10, "buzz_timeout");

    // alarm_on dropped at tick 3.
    trigger(1'b1);
    tick_pair(1'b1, 1'b1, "drop_tick1");
    tick_pair(1'b1, 1'b1, "drop_tick2");
    alarm_on = 1'b0;
    tick_pair(1'b1, 1'b0, "drop_tick3");

    // Match with alarm disarmed.
    trigger(1'b0);
    alarm_on = 1'b1;
    bus.sec_ct = 7'd1;
    cyc(9'h0, BUZ, "rearm_idle");

    // Mode change while buzzing.
    trigger(1'b1);
    set_time = 1'b1;
    cyc(BUZ, BUZ | MODE, "mode_chg_req");
    cyc(md(2'd1), MODE, "mode_chg_mode");
    cyc(CLR | md(2'd1), CLR | MODE | BUZ, "mode_chg_clears_buzz");
    set_time = 1'b0;
    cyc(md(2'd1), MODE | BUZ, "mode_chg_exit");
    cyc(md(2'd0), MODE | BUZ, "mode_chg_run");

`ifdef ALARM_SNOOZE_EN
    trigger(1'b1);
    snooze = 1'b1;
    cyc(BUZ, BUZ, "snooze_press");
    cyc(9'h0, BUZ, "snooze_silences");
    snooze = 1'b0;
    bus.hr_ct = 7'd8; bus.min_ct = 7'd0; bus.sec_ct = 7'd5;
    for (int k = 1; k <= 60; k++) tick_pair(1'b0, k == 60, "snooze_wait");
    cyc(BUZ, BUZ, "snooze_rebuzz");
    alarm_on = 1'b0;
    cyc(BUZ, BUZ, "snooze_disarm_req");
    cyc(9'h0, BUZ, "snooze_disarm");
`else
    trigger(1'b1);
    snooze = 1'b1;
    cyc(BUZ, BUZ, "snooze_press");
    cyc(BUZ, BUZ, "snooze_ignored");
    snooze = 1'b0;
    alarm_on = 1'b0;
    cyc(BUZ, BUZ, "disarm_req");
    cyc(9'h0, BUZ, "disarm");
`endif

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
